// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if
//   Wide-beat valid/ready stream produced by fifo_rd_packer.
//   Signals:
//     m_data  [IN_W*RATIO]  packed beat, lane k = bits [k*IN_W +: IN_W], lane 0 = oldest word
//     m_keep  [RATIO]       lane k carries valid data
//     m_valid               beat valid
//     m_ready               sink accepts the beat when m_valid && m_ready
//   Modports: master (packer side), slave (downstream sink side).
interface fifo_rd_packer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  logic [IN_W*RATIO-1:0] m_data;
  logic [RATIO-1:0]      m_keep;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_keep, output m_valid, input m_ready);
  modport slave  (input m_data, input m_keep, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side consumer of a first-word-fall-through FIFO. Pops FIFO words and packs
//   RATIO consecutive words into one wide beat, lane 0 first. A flush request closes a
//   partially filled beat; unused lanes are zero and m_keep marks the filled lanes.
//   Optional feature macro: FIFO_RD_PACKER_TIMEOUT_EN -- when defined, a partial beat
//   that sees TIMEOUT consecutive cycles without a pop is closed as if flushed.
//   Ports:
//     clock, reset  single clock, synchronous active-high reset
//     fifo_dout     FIFO head word (valid while !fifo_empty)
//     fifo_empty    FIFO empty flag
//     fifo_rd       pop strobe, never high while fifo_empty
//     flush         one-cycle request to close the current partial beat
//     m             fifo_rd_packer_if.master output beat stream
module fifo_rd_packer #(
  parameter int IN_W    = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [IN_W-1:0]        fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_rd,
  input  logic                   flush,
  fifo_rd_packer_if.master       m
);

  localparam int IDX_W = $clog2(RATIO);
  localparam int OUT_W = IN_W * RATIO;

  typedef enum logic {FILL = 1'b0, DONE = 1'b1} acc_state_t;

  acc_state_t       state, state_nxt;
  logic [OUT_W-1:0] acc_data, acc_data_nxt;
  logic [RATIO-1:0] acc_keep, acc_keep_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             out_free;
  logic             pop;
  logic             drain;
  logic             flush_eff;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] timer;
  logic             tmo_hit;

  // Idle cycles are counted only while a partial beat is open; a pop restarts the count.
  assign tmo_hit   = (state == FILL) && (idx != '0) && !pop && (timer == TMR_W'(TIMEOUT - 1));
  assign flush_eff = flush || tmo_hit;

  always_ff @(posedge clock) begin
    if (reset)
      timer <= '0;
    else if ((state != FILL) || pop || (idx == '0) || tmo_hit)
      timer <= '0;
    else
      timer <= timer + 1'b1;
  end
`else
  assign flush_eff = flush;
`endif

  assign out_free = !m.m_valid || m.m_ready;
  // A completed accumulator may only accept a new word in the cycle it hands off.
  assign pop      = !reset && !fifo_empty && ((state == FILL) || out_free);
  assign drain    = (state == DONE) && out_free;
  assign fifo_rd  = pop;

  always_comb begin
    state_nxt    = state;
    acc_data_nxt = acc_data;
    acc_keep_nxt = acc_keep;
    idx_nxt      = idx;
    if (drain) begin
      // Hand-off cycle: a word popped now starts the next beat in lane 0.
      state_nxt    = FILL;
      acc_data_nxt = '0;
      acc_keep_nxt = '0;
      idx_nxt      = '0;
      if (pop) begin
        acc_data_nxt[IN_W-1:0] = fifo_dout;
        acc_keep_nxt[0]        = 1'b1;
        idx_nxt                = IDX_W'(1);
      end
    end else if (state == FILL) begin
      if (pop) begin
        acc_data_nxt[idx*IN_W +: IN_W] = fifo_dout;
        acc_keep_nxt[idx]              = 1'b1;
      end
      if (pop && (idx == IDX_W'(RATIO - 1)))
        state_nxt = DONE;
      else if (flush_eff && ((idx != '0) || pop))
        state_nxt = DONE;
      else if (pop)
        idx_nxt = idx + 1'b1;
    end
  end

  // Accumulator stage
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= FILL;
      acc_data <= '0;
      acc_keep <= '0;
      idx      <= '0;
    end else begin
      state    <= state_nxt;
      acc_data <= acc_data_nxt;
      acc_keep <= acc_keep_nxt;
      idx      <= idx_nxt;
    end
  end

  // Output register stage
  always_ff @(posedge clock) begin
    if (reset) begin
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
      m.m_keep  <= '0;
    end else if (drain) begin
      m.m_valid <= 1'b1;
      m.m_data  <= acc_data;
      m.m_keep  <= acc_keep;
    end else if (m.m_ready) begin
      m.m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;
  localparam int IN_W    = 8;
  localparam int RATIO   = 4;
  localparam int TIMEOUT = 64;
  localparam int OW      = IN_W * RATIO;

  logic            clock = 1'b0;
  logic            reset;
  logic [IN_W-1:0] fifo_dout;
  logic            fifo_empty;
  logic            fifo_rd;
  logic            flush;

  fifo_rd_packer_if #(.IN_W(IN_W), .RATIO(RATIO)) bus ();

  fifo_rd_packer #(.IN_W(IN_W), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .m          (bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // FIFO contents and reference model
  logic [IN_W-1:0]  src_q[$];
  bit               gate_empty = 1'b0;
  logic [IN_W-1:0]  grp[$];
  logic [OW-1:0]    exp_d[$];
  logic [RATIO-1:0] exp_k[$];

  int cyc_n = 0;
  int pop_cnt = 0;
  int last_pop_cyc = 0;
  int beat_cnt = 0;
  int last_beat_cyc = 0;
  int idle_cnt = 0;
  logic [OW-1:0]    last_beat_d = '0;
  logic [RATIO-1:0] last_beat_k = '0;
  logic             prev_stall = 1'b0;
  logic [OW-1:0]    prev_d = '0;
  logic [RATIO-1:0] prev_k = '0;

  function automatic void close_grp();
    logic [OW-1:0]    d = '0;
    logic [RATIO-1:0] k = '0;
    foreach (grp[i]) begin
      d[i*IN_W +: IN_W] = grp[i];
      k[i] = 1'b1;
    end
    exp_d.push_back(d);
    exp_k.push_back(k);
    grp.delete();
    idle_cnt = 0;
  endfunction

  task automatic drive_fifo();
    fifo_empty = gate_empty || (src_q.size() == 0);
    fifo_dout  = (src_q.size() != 0) ? src_q[0] : IN_W'($urandom);
  endtask

  task automatic push_words(input logic [IN_W-1:0] first, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(first + IN_W'(i));
    drive_fifo();
  endtask

  // One clock: observe at the falling edge, update the model, drive after the rising edge.
  task automatic cyc();
    logic rd;
    logic [OW-1:0]    ed;
    logic [RATIO-1:0] ek;
    @(negedge clock);
    cyc_n++;
    rd = fifo_rd;
    vectors++;
    if (rd === 1'b1 && fifo_empty) begin
      miscompares++;
      $display("FAIL pop_while_empty: fifo_rd=%b required 0 (cycle %0d)", rd, cyc_n);
    end
    if (reset) begin
      vectors++;
      if (rd !== 1'b0) begin
        miscompares++;
        $display("FAIL pop_in_reset: fifo_rd=%b required 0", rd);
      end
    end else if (!fifo_empty && bus.m_ready) begin
      vectors++;
      if (rd !== 1'b1) begin
        miscompares++;
        $display("FAIL pop_when_ready: fifo_rd=%b required 1 (cycle %0d)", rd, cyc_n);
      end
    end
    if (prev_stall) begin
      vectors++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== prev_d || bus.m_keep !== prev_k) begin
        miscompares++;
        $display("FAIL hold_stable: valid=%b data=%h keep=%h required 1 %h %h",
                 bus.m_valid, bus.m_data, bus.m_keep, prev_d, prev_k);
      end
    end
    if (!reset && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      beat_cnt++;
      last_beat_cyc = cyc_n;
      last_beat_d = bus.m_data;
      last_beat_k = bus.m_keep;
      vectors++;
      if (exp_d.size() == 0) begin
        miscompares++;
        $display("FAIL beat_unexpected: data=%h keep=%h required no beat", bus.m_data, bus.m_keep);
      end else begin
        ed = exp_d.pop_front();
        ek = exp_k.pop_front();
        if (bus.m_data !== ed || bus.m_keep !== ek) begin
          miscompares++;
          $display("FAIL beat_content: data=%h keep=%h required %h %h",
                   bus.m_data, bus.m_keep, ed, ek);
        end
      end
    end
    if (reset) begin
      grp.delete();
      idle_cnt = 0;
    end else begin
      if (rd === 1'b1) begin
        grp.push_back(fifo_dout);
        pop_cnt++;
        last_pop_cyc = cyc_n;
        idle_cnt = 0;
      end else if (grp.size() > 0) begin
        idle_cnt++;
      end
      if (grp.size() == RATIO)
        close_grp();
      else if (grp.size() > 0 && flush)
        close_grp();
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
      else if (grp.size() > 0 && idle_cnt == TIMEOUT)
        close_grp();
`endif
    end
    prev_stall = !reset && (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
    prev_d = bus.m_data;
    prev_k = bus.m_keep;
    @(posedge clock);
    #1;
    if (rd === 1'b1 && src_q.size() != 0) void'(src_q.pop_front());
    flush = 1'b0;
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.m_ready = 1'b1;
    push_words(8'hE0, 2);
    run(2);
    vectors++;
    if (fifo_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_fifo_rd: got %b required 0", fifo_rd);
    end
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_m_valid: got %b required 0", bus.m_valid);
    end
    vectors++;
    if (bus.m_data !== '0 || bus.m_keep !== '0) begin
      miscompares++;
      $display("FAIL reset_m_data_keep: got %h %h required 0 0", bus.m_data, bus.m_keep);
    end
    src_q.delete();
    drive_fifo();
    reset = 1'b0;
    run(2);
  endtask

  task automatic test_single_beat();
    int b0 = beat_cnt;
    bus.m_ready = 1'b1;
    push_words(8'h01, 4);
    run(10);
    vectors++;
    if (beat_cnt - b0 != 1) begin
      miscompares++;
      $display("FAIL single_beat_count: got %0d required 1", beat_cnt - b0);
    end
    vectors++;
    if (last_beat_d !== 32'h04030201 || last_beat_k !== 4'hF) begin
      miscompares++;
      $display("FAIL single_beat_data: got %h %h required 04030201 f", last_beat_d, last_beat_k);
    end
    vectors++;
    if (last_beat_cyc - last_pop_cyc != 2) begin
      miscompares++;
      $display("FAIL single_beat_latency: got %0d required 2", last_beat_cyc - last_pop_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int b0 = beat_cnt;
    int p0 = pop_cnt;
    int first = 0;
    bus.m_ready = 1'b1;
    push_words(8'h10, 8);
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (pop_cnt == p0 + 1 && first == 0) first = last_pop_cyc;
    end
    vectors++;
    if (pop_cnt - p0 != 8 || last_pop_cyc - first != 7) begin
      miscompares++;
      $display("FAIL stream_pops: got %0d pops over %0d cycles required 8 over 8",
               pop_cnt - p0, last_pop_cyc - first + 1);
    end
    vectors++;
    if (beat_cnt - b0 != 2 || last_beat_d !== 32'h17161514) begin
      miscompares++;
      $display("FAIL stream_beats: got %0d last %h required 2 last 17161514",
               beat_cnt - b0, last_beat_d);
    end
    vectors++;
    if (last_beat_cyc - last_pop_cyc != 2) begin
      miscompares++;
      $display("FAIL stream_latency: got %0d required 2", last_beat_cyc - last_pop_cyc);
    end
  endtask

  task automatic test_flush();
    int b0 = beat_cnt;
    bus.m_ready = 1'b1;
    push_words(8'hAA, 1);
    push_words(8'hBB, 1);
    run(4);
    flush = 1'b1;
    run(5);
    vectors++;
    if (beat_cnt - b0 != 1 || last_beat_d !== 32'h0000BBAA || last_beat_k !== 4'h3) begin
      miscompares++;
      $display("FAIL flush_partial: got %0d beats %h %h required 1 0000bbaa 3",
               beat_cnt - b0, last_beat_d, last_beat_k);
    end
    b0 = beat_cnt;
    flush = 1'b1;
    run(6);
    vectors++;
    if (beat_cnt != b0) begin
      miscompares++;
      $display("FAIL flush_empty: got %0d beats required 0", beat_cnt - b0);
    end
  endtask

  task automatic test_backpressure();
    int b0 = beat_cnt;
    int p0 = pop_cnt;
    bus.m_ready = 1'b0;
    push_words(8'h20, 12);
    run(20);
    vectors++;
    if (pop_cnt - p0 != 8) begin
      miscompares++;
      $display("FAIL stall_pops: got %0d required 8", pop_cnt - p0);
    end
    vectors++;
    if (fifo_rd !== 1'b0 || fifo_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_fifo_rd: got rd=%b empty=%b required 0 0", fifo_rd, fifo_empty);
    end
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h23222120) begin
      miscompares++;
      $display("FAIL stall_held: got %b %h required 1 23222120", bus.m_valid, bus.m_data);
    end
    bus.m_ready = 1'b1;
    run(20);
    vectors++;
    if (beat_cnt - b0 != 3 || pop_cnt - p0 != 12 || last_beat_d !== 32'h2B2A2928) begin
      miscompares++;
      $display("FAIL stall_drain: got %0d beats %0d pops last %h required 3 12 2b2a2928",
               beat_cnt - b0, pop_cnt - p0, last_beat_d);
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    bus.m_ready = 1'b1;
    push_words(8'h50, 2);
    run(4);
    push_words(8'h60, 4);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_valid: got %b required 0", bus.m_valid);
    end
    b0 = beat_cnt;
    run(10);
    vectors++;
    if (beat_cnt - b0 != 1 || last_beat_d !== 32'h63626160 || last_beat_k !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_mid_fresh: got %0d beats %h %h required 1 63626160 f",
               beat_cnt - b0, last_beat_d, last_beat_k);
    end
  endtask

  task automatic test_timeout();
    int b0 = beat_cnt;
    bus.m_ready = 1'b1;
    push_words(8'hCC, 1);
    run(TIMEOUT + 30);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    vectors++;
    if (beat_cnt - b0 != 1 || last_beat_d !== 32'h000000CC || last_beat_k !== 4'h1) begin
      miscompares++;
      $display("FAIL timeout_beat: got %0d beats %h %h required 1 000000cc 1",
               beat_cnt - b0, last_beat_d, last_beat_k);
    end
    vectors++;
    if (last_beat_cyc - last_pop_cyc != TIMEOUT + 2) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d required %0d",
               last_beat_cyc - last_pop_cyc, TIMEOUT + 2);
    end
`else
    vectors++;
    if (beat_cnt != b0) begin
      miscompares++;
      $display("FAIL timeout_disabled: got %0d beats required 0", beat_cnt - b0);
    end
    flush = 1'b1;
    run(4);
    vectors++;
    if (beat_cnt - b0 != 1 || last_beat_d !== 32'h000000CC || last_beat_k !== 4'h1) begin
      miscompares++;
      $display("FAIL timeout_disabled_flush: got %0d beats %h %h required 1 000000cc 1",
               beat_cnt - b0, last_beat_d, last_beat_k);
    end
`endif
  endtask

  task automatic test_random();
    int p0 = pop_cnt;
    for (int i = 0; i < 60; i++) src_q.push_back(IN_W'($urandom));
    for (int i = 0; i < 400; i++) begin
      bus.m_ready = ($urandom_range(0, 9) < 7);
      gate_empty  = ($urandom_range(0, 9) < 3);
      drive_fifo();
      cyc();
    end
    bus.m_ready = 1'b1;
    gate_empty = 1'b0;
    drive_fifo();
    run(20);
    flush = 1'b1;
    run(6);
    vectors++;
    if (pop_cnt - p0 != 60) begin
      miscompares++;
      $display("FAIL random_pops: got %0d required 60", pop_cnt - p0);
    end
    vectors++;
    if (exp_d.size() != 0 || grp.size() != 0) begin
      miscompares++;
      $display("FAIL random_drain: %0d beats and %0d words outstanding required 0 0",
               exp_d.size(), grp.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.m_ready = 1'b0;
    drive_fifo();
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
